// File: rtl/stepper_sequencer.sv
// ============================================================================
// stepper_sequencer : homes one stepper axis, queues and issues move commands,
// tracks position from step pulses. Optional backoff: define SEQ_BACKOFF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stepper_sequencer #(
   parameter int FIFO_DEPTH    = 4,
   parameter int MAX_SPEED     = 20,
   parameter int HOME_TIMEOUT  = 50_000_000,
   parameter int DEBOUNCE      = 16,
   parameter int SETTLE_CYCLES = 1000,
   parameter int BACKOFF_STEPS = 200
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_speed,
   input  logic [23:0] cmd_pos,
   input  logic        home_req,
   input  logic        abort,
   input  logic        limit_sw,
   input  logic        step_in,
   input  logic        dir_in,
   output logic [31:0] control_out,
   output logic        homing_enable,
   output logic        stepper_reset,
   output logic [23:0] position,
   output logic        busy,
   output logic        homed,
   output logic        done_pulse,
   output logic        cmd_err,
   output logic        error
);

   localparam int          C_PTR_W        = $clog2(FIFO_DEPTH);
   localparam logic [31:0] C_DB_LAST      = 32'(DEBOUNCE - 1);
   localparam logic [31:0] C_TIMEOUT_LAST = 32'(HOME_TIMEOUT - 1);
   localparam logic [31:0] C_SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOME_SEEK,
      S_HOME_ZERO,
      S_READY,
      S_MOVE,
      S_SETTLE,
      S_FAULT
`ifdef SEQ_BACKOFF_EN
      , S_BACKOFF
`endif
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_cnt, w_cnt_nxt;
   logic [31:0]   r_ctrl, w_ctrl_nxt;
   logic [23:0]   r_target, w_target_nxt;
   logic          r_homed, w_homed_nxt;
   logic          r_done, w_done_nxt;
   logic          r_cmd_err, w_err_nxt;
   logic          r_error, r_homing_en, r_stepper_rst;
   logic [23:0]   r_position;
   logic          w_pop, w_flush, w_rehome, w_illegal;
   logic [31:0]   w_idle_ctrl;
`ifdef SEQ_BACKOFF_EN
   logic          r_bo_done, w_bo_done_nxt;
`endif

   // limit switch: two-flop synchroniser followed by a stability counter
   logic          r_lim_s1, r_lim_s2, r_lim_db, r_lim_db_d;
   logic [31:0]   r_db_cnt;
   logic          w_lim_rise;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lim_s1   <= 1'b0;
         r_lim_s2   <= 1'b0;
         r_lim_db   <= 1'b0;
         r_lim_db_d <= 1'b0;
         r_db_cnt   <= '0;
      end else begin
         r_lim_s1   <= limit_sw;
         r_lim_s2   <= r_lim_s1;
         r_lim_db_d <= r_lim_db;
         if (r_lim_s2 != r_lim_db) begin
            if (r_db_cnt >= C_DB_LAST) begin
               r_lim_db <= r_lim_s2;
               r_db_cnt <= '0;
            end else begin
               r_db_cnt <= r_db_cnt + 32'd1;
            end
         end else begin
            r_db_cnt <= '0;
         end
      end
   end

   assign w_lim_rise = r_lim_db & ~r_lim_db_d;

   // command FIFO, pointers carry one extra wrap bit
   logic [31:0]        r_fifo [FIFO_DEPTH];
   logic [C_PTR_W:0]   r_wr_ptr, r_rd_ptr;
   logic               w_full, w_empty, w_push;
   logic [31:0]        w_head;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[C_PTR_W] != r_rd_ptr[C_PTR_W]) &&
                      (r_wr_ptr[C_PTR_W-1:0] == r_rd_ptr[C_PTR_W-1:0]);
   assign cmd_ready = !w_full && (r_state != S_FAULT);
   assign w_push    = cmd_valid && cmd_ready;
   assign w_head    = r_fifo[r_rd_ptr[C_PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr[C_PTR_W-1:0]] <= {cmd_speed, cmd_pos};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // position follows rising edges of the generator's step output
   logic r_step_d;
   logic w_step_rise;

   assign w_step_rise = step_in & ~r_step_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_step_d   <= 1'b0;
         r_position <= '0;
      end else begin
         r_step_d <= step_in;
         if (r_state == S_HOME_ZERO) begin
            r_position <= '0;
         end else if (w_step_rise && (r_state != S_HOME_SEEK)) begin
            r_position <= dir_in ? (r_position - 24'd1) : (r_position + 24'd1);
         end
      end
   end

   assign w_illegal   = (w_head[31:24] == 8'd0) || (w_head[31:24] > 8'(MAX_SPEED));
   assign w_rehome    = home_req && ((r_state == S_MOVE) || (r_state == S_SETTLE));
   assign w_idle_ctrl = {8'd0, r_position};

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = '0;
      w_ctrl_nxt   = r_ctrl;
      w_target_nxt = r_target;
      w_homed_nxt  = r_homed;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      w_pop        = 1'b0;
      w_flush      = 1'b0;
`ifdef SEQ_BACKOFF_EN
      w_bo_done_nxt = r_bo_done;
`endif
      case (r_state)
         S_IDLE: begin
            w_homed_nxt = 1'b0;
            if (home_req) w_state_nxt = S_HOME_SEEK;
         end
         S_HOME_SEEK: begin
            w_cnt_nxt = r_cnt + 32'd1;
            if (r_lim_db) begin
               w_state_nxt = S_HOME_ZERO;
               w_cnt_nxt   = '0;
            end else if (r_cnt >= C_TIMEOUT_LAST) begin
               w_state_nxt = S_FAULT;
            end
         end
         S_HOME_ZERO: begin
            w_ctrl_nxt = '0;
            w_cnt_nxt  = r_cnt + 32'd1;
            if (r_cnt[0]) begin
               w_cnt_nxt = '0;
`ifdef SEQ_BACKOFF_EN
               if (r_bo_done) begin
                  w_state_nxt   = S_READY;
                  w_homed_nxt   = 1'b1;
                  w_bo_done_nxt = 1'b0;
               end else begin
                  w_state_nxt = S_BACKOFF;
                  w_ctrl_nxt  = {8'd1, 24'(BACKOFF_STEPS)};
               end
`else
               w_state_nxt = S_READY;
               w_homed_nxt = 1'b1;
`endif
            end
         end
`ifdef SEQ_BACKOFF_EN
         S_BACKOFF: begin
            if (r_position == 24'(BACKOFF_STEPS)) begin
               if (r_lim_db) begin
                  w_state_nxt = S_FAULT;
               end else begin
                  w_state_nxt   = S_HOME_ZERO;
                  w_bo_done_nxt = 1'b1;
               end
            end
         end
`endif
         S_READY: begin
            if (home_req) begin
               w_state_nxt = S_HOME_SEEK;
               w_homed_nxt = 1'b0;
            end else if (!w_empty && !r_done) begin
               // hold off one cycle after done_pulse so the host sees it first
               w_pop = 1'b1;
               if (w_illegal) begin
                  w_err_nxt = 1'b1;
               end else if (w_head[23:0] == r_position) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_ctrl_nxt   = w_head;
                  w_target_nxt = w_head[23:0];
                  w_state_nxt  = S_MOVE;
               end
            end
         end
         S_MOVE: begin
            if (w_lim_rise && dir_in) begin
               w_state_nxt = S_FAULT;
            end else if (r_position == r_target) begin
               w_state_nxt = S_SETTLE;
               w_cnt_nxt   = 32'd1;
            end
         end
         S_SETTLE: begin
            w_cnt_nxt = r_cnt + 32'd1;
            if (r_cnt >= C_SETTLE_LAST) begin
               w_state_nxt = S_READY;
               w_done_nxt  = 1'b1;
               w_cnt_nxt   = '0;
            end
         end
         default: ;
      endcase

      if (w_rehome) begin
         w_state_nxt = S_HOME_SEEK;
         w_flush     = 1'b1;
         w_ctrl_nxt  = w_idle_ctrl;
         w_homed_nxt = 1'b0;
         w_done_nxt  = 1'b0;
         w_cnt_nxt   = '0;
      end

      if (abort) begin
         w_state_nxt = r_homed ? S_READY : S_IDLE;
         w_flush     = 1'b1;
         w_pop       = 1'b0;
         w_ctrl_nxt  = w_idle_ctrl;
         w_done_nxt  = 1'b0;
         w_err_nxt   = 1'b0;
         w_cnt_nxt   = '0;
`ifdef SEQ_BACKOFF_EN
         w_bo_done_nxt = 1'b0;
`endif
      end

      if (w_state_nxt == S_FAULT) begin
         w_flush     = 1'b1;
         w_pop       = 1'b0;
         w_ctrl_nxt  = w_idle_ctrl;
         w_homed_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_ctrl        <= '0;
         r_target      <= '0;
         r_homed       <= 1'b0;
         r_done        <= 1'b0;
         r_cmd_err     <= 1'b0;
         r_error       <= 1'b0;
         r_homing_en   <= 1'b0;
         r_stepper_rst <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_ctrl        <= w_ctrl_nxt;
         r_target      <= w_target_nxt;
         r_homed       <= w_homed_nxt;
         r_done        <= w_done_nxt;
         r_cmd_err     <= w_err_nxt;
         r_error       <= (w_state_nxt == S_FAULT);
         r_homing_en   <= (w_state_nxt == S_HOME_SEEK);
         r_stepper_rst <= (w_state_nxt == S_HOME_ZERO);
      end
   end

`ifdef SEQ_BACKOFF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_bo_done <= 1'b0;
      else          r_bo_done <= w_bo_done_nxt;
   end

   assign busy = (r_state == S_HOME_SEEK) || (r_state == S_HOME_ZERO) ||
                 (r_state == S_BACKOFF)   || (r_state == S_MOVE) || (r_state == S_SETTLE);
`else
   assign busy = (r_state == S_HOME_SEEK) || (r_state == S_HOME_ZERO) ||
                 (r_state == S_MOVE)      || (r_state == S_SETTLE);
`endif

   assign control_out   = r_ctrl;
   assign homing_enable = r_homing_en;
   assign stepper_reset = r_stepper_rst;
   assign position      = r_position;
   assign homed         = r_homed;
   assign done_pulse    = r_done;
   assign cmd_err       = r_cmd_err;
   assign error         = r_error;

endmodule

`default_nettype wire

// File: tb/tb_stepper_sequencer.sv
// ============================================================================
// tb_stepper_sequencer : directed self-checking bench for stepper_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stepper_sequencer;

   localparam int HT = 3000;
   localparam int DB = 16;
   localparam int ST = 40;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_speed = '0;
   logic [23:0] cmd_pos = '0;
   logic        home_req = 1'b0;
   logic        abort = 1'b0;
   logic        limit_sw = 1'b0;
   logic        step_in = 1'b0;
   logic        dir_in = 1'b0;
   logic [31:0] control_out;
   logic        homing_enable, stepper_reset, busy, homed, done_pulse, cmd_err, error;
   logic [23:0] position;

   int n_checks = 0;
   int n_pass   = 0;

   stepper_sequencer #(
      .FIFO_DEPTH(4), .MAX_SPEED(20), .HOME_TIMEOUT(HT),
      .DEBOUNCE(DB), .SETTLE_CYCLES(ST), .BACKOFF_STEPS(200)
   ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_speed(cmd_speed), .cmd_pos(cmd_pos),
      .home_req(home_req), .abort(abort), .limit_sw(limit_sw),
      .step_in(step_in), .dir_in(dir_in),
      .control_out(control_out), .homing_enable(homing_enable),
      .stepper_reset(stepper_reset), .position(position),
      .busy(busy), .homed(homed), .done_pulse(done_pulse),
      .cmd_err(cmd_err), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic push(input logic [7:0] spd, input logic [23:0] pos);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_speed = spd; cmd_pos = pos;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic steps(input int n, input logic dir);
      dir_in = dir;
      for (int i = 0; i < n; i++) begin
         step_in = 1'b1;
         @(negedge clk);
         step_in = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic pulse_home();
      @(negedge clk); home_req = 1'b1;
      @(negedge clk); home_req = 1'b0;
   endtask

   task automatic pulse_abort();
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
   endtask

   task automatic wait_done(input int max, output int n, output bit seen);
      n = 0; seen = 1'b0;
      while (!seen && n < max) begin
         @(posedge clk); #1;
         n++;
         seen = done_pulse;
      end
   endtask

   task automatic home_quiet();
      int n;
      pulse_home();
      repeat (20) @(negedge clk);
      limit_sw = 1'b1;
      n = 0;
      while (!homed && n < 200) begin @(negedge clk); n++; end
      chk("rehome_homed", {31'd0, homed}, 32'd1);
      chk("rehome_pos", {8'd0, position}, 32'd0);
      limit_sw = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   initial begin
      int  n, errs, dones, busies;
      bit  seen;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_ctrl", control_out, 32'd0);
      chk("rst_srst", {31'd0, stepper_reset}, 32'd1);
      chk("rst_pos", {8'd0, position}, 32'd0);
      chk("rst_flags", {26'd0, homing_enable, busy, homed, done_pulse, cmd_err, error}, 32'd0);
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("srst_release", {31'd0, stepper_reset}, 32'd0);

      // steps counted while idle, later zeroed by homing
      @(negedge clk);
      steps(3, 1'b0);
      chk("idle_steps", {8'd0, position}, 32'd3);

      // homing: homing_enable drops DB+3 cycles after limit goes high
      pulse_home();
      chk("seek_hen", {30'd0, homing_enable, busy}, 32'd3);
      repeat (50) @(negedge clk);
      limit_sw = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (homing_enable && n < 200);
      chk("home_latency", n, DB + 3);
      chk("zero_srst1", {31'd0, stepper_reset}, 32'd1);
      @(posedge clk); #1;
      chk("zero_srst2", {31'd0, stepper_reset}, 32'd1);
      @(posedge clk); #1;
      chk("zero_srst_end", {31'd0, stepper_reset}, 32'd0);
      chk("home_done", {30'd0, homed, busy}, 32'd2);
      chk("home_pos", {8'd0, position}, 32'd0);
      @(negedge clk);
      limit_sw = 1'b0;
      repeat (30) @(negedge clk);

      // single move with settle timing
      push(8'd5, 24'd100);
      @(negedge clk);
      chk("move_ctrl", control_out, 32'h0500_0064);
      chk("move_busy", {31'd0, busy}, 32'd1);
      steps(99, 1'b0);
      step_in = 1'b1;
      @(posedge clk); #1;
      step_in = 1'b0;
      chk("move_pos", {8'd0, position}, 32'd100);
      wait_done(200, n, seen);
      chk("settle_latency", n, ST);
      @(posedge clk); #1;
      chk("done_one_cycle", {30'd0, done_pulse, busy}, 32'd0);

      // fill FIFO behind an active move
      push(8'd3, 24'd110);
      push(8'd0, 24'd5);
      push(8'd21, 24'd7);
      push(8'd4, 24'd105);
      chk("ready_before_full", {31'd0, cmd_ready}, 32'd1);
      push(8'd6, 24'd105);
      chk("full_ready", {31'd0, cmd_ready}, 32'd0);
      push(8'd9, 24'd9);
      steps(10, 1'b0);
      wait_done(200, n, seen);
      chk("moveA_done", {31'd0, seen}, 32'd1);
      errs = 0; dones = 0; n = 0;
      do begin
         @(posedge clk); #1; n++;
         errs += int'(cmd_err); dones += int'(done_pulse);
      end while (!busy && n < 30);
      chk("illegal_errs", errs, 2);
      chk("illegal_no_done", dones, 0);
      chk("moveC_ctrl", control_out, 32'h0400_0069);
      @(negedge clk);
      steps(5, 1'b1);
      chk("moveC_pos", {8'd0, position}, 32'd105);
      wait_done(200, n, seen);
      chk("moveC_done", {31'd0, seen}, 32'd1);
      wait_done(10, n, seen);
      chk("samepos_done", {31'd0, seen}, 32'd1);
      chk("samepos_ctrl", control_out, 32'h0400_0069);
      errs = 0; busies = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         errs += int'(cmd_err); busies += int'(busy);
      end
      chk("fifth_refused", errs + busies, 0);

      // homing timeout
      @(negedge clk);
      home_req = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
         if (n == 1) home_req = 1'b0;
      end while (!error && n < HT + 100);
      chk("timeout_cycles", n, HT + 1);
      chk("fault_ready", {30'd0, cmd_ready, homed}, 32'd0);
      chk("fault_ctrl", control_out, 32'h0000_0069);
      pulse_abort();
      chk("fault_abort", {29'd0, error, busy, homed}, 32'd0);
      chk("abort_ready", {31'd0, cmd_ready}, 32'd1);

      // abort mid-move
      home_quiet();
      push(8'd7, 24'd50);
      push(8'd7, 24'd60);
      steps(20, 1'b0);
      pulse_abort();
      chk("abort_ctrl", control_out, 32'h0000_0014);
      chk("abort_state", {30'd0, busy, homed}, 32'd1);
      dones = 0; busies = 0;
      for (int i = 0; i < ST + 60; i++) begin
         @(posedge clk); #1;
         dones += int'(done_pulse); busies += int'(busy);
      end
      chk("abort_no_done", dones, 0);
      chk("abort_flushed", busies, 0);

      // wrap to 0xFFFFFF, then limit fault while moving negative
      @(negedge clk);
      home_quiet();
      push(8'd2, 24'hFF_FFFF);
      @(negedge clk);
      chk("wrap_ctrl", control_out, 32'h02FF_FFFF);
      steps(1, 1'b1);
      chk("wrap_pos", {8'd0, position}, 32'h00FF_FFFF);
      wait_done(200, n, seen);
      chk("wrap_done", {31'd0, seen}, 32'd1);
      push(8'd2, 24'hFF_FFF0);
      @(negedge clk);
      dir_in = 1'b1;
      limit_sw = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!error && n < 100);
      chk("limit_fault", {31'd0, error}, 32'd1);
      chk("limit_fault_ctrl", control_out, 32'h00FF_FFFF);
      pulse_abort();
      limit_sw = 1'b0;
      chk("limit_abort", {30'd0, error, homed}, 32'd0);
      steps(1, 1'b0);
      chk("wrap_up_pos", {8'd0, position}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
